mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter sharing one backing memory between the instruction-fetch (IF) port and the data-access (MA) port of the pipelined RV32IM core. Each requester sees a stall-style BUSYWAIT interface. The arbiter sequences one access at a time to the memory and handles the memory's BUSYWAIT handshake. Data accesses have priority; a starvation counter guarantees forward progress for fetch.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch is pending before fetch is forced (≥1).
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- I_REQ  in  1  fetch request, held until I_BUSYWAIT is low.
- I_ADDR  in  32  fetch address.
- I_DATA  out  32  fetched instruction, valid when I_BUSYWAIT is low in the RESP cycle.
- I_BUSYWAIT  out  1  fetch stall.
- D_READ  in  4  bit3 is read enable; [2:0] is funct3 (LB/LH/LW/LBU/LHU).
- D_WRITE  in  3  bit2 is write enable; [1:0] is size (00 = B, 01 = H, 10 = W).
- D_ADDR  in  32  data address.
- D_WRITEDATA  in  32  store data.
- D_READDATA  out  32  load data.
- D_BUSYWAIT  out  1  data stall.
- M_READ  out  4  memory read control, same encoding as D_READ.
- M_WRITE  out  3  memory write control, same encoding as D_WRITE.
- M_ADDR  out  32  memory address.
- M_WRITEDATA  out  32  memory store data.
- M_READDATA  in  32  memory read data.
- M_BUSYWAIT  in  1  memory busy. Memory asserts it while an access is in progress; low means complete.

## Operation
- States:
  - IDLE: no access in progress.
  - ACC: an access is driven to memory.
  - RESP: one-cycle completion response.
- The owner register (I or D) and the starve count (0..STARVE_LIMIT) are reset to D and 0.
- Data request: dreq = D_READ[3] | D_WRITE[2]. If both are set, the access is a write and D_READ is ignored.
- Grant rule in IDLE, at the edge:
  - Fetch is granted if I_REQ & (!dreq | starve == STARVE_LIMIT).
  - Otherwise data is granted if dreq.
  - Otherwise the arbiter stays in IDLE.
- On grant, the arbiter latches address, control and write data into the M_* registers and moves to ACC.
  - Fetch drives M_READ = 4'b1010 and M_WRITE = 0.
  - A data read drives M_READ = D_READ and M_WRITE = 0.
  - A data write drives M_WRITE = D_WRITE and M_READ = 0.
- Starve count:
  - Increments on a data grant made while I_REQ is high, saturating at STARVE_LIMIT.
  - Clears on a fetch grant, or on a data grant made with I_REQ low.
- ACC: M_* are held stable. At an edge where M_BUSYWAIT = 0:
  - M_READDATA is captured into I_DATA (owner I) or into D_READDATA (owner D, read only).
  - M_READ and M_WRITE clear.
  - The state moves to RESP.
- RESP: lasts one cycle, then returns to IDLE unconditionally.
- Busywait outputs (combinational):
  - I_BUSYWAIT = I_REQ & !(state == RESP & owner == I).
  - D_BUSYWAIT = dreq & !(state == RESP & owner == D).
  - A port with no request never stalls.
- I_DATA and D_READDATA hold their last captured values. A write does not modify D_READDATA.
- Requester inputs are ignored outside IDLE. Changing them mid-access has no effect on the access in flight.

## Timing
- Reset values: state IDLE; M_READ 0; M_WRITE 0; M_ADDR 0; M_WRITEDATA 0; I_DATA 0; D_READDATA 0; starve 0.
- During reset, I_BUSYWAIT and D_BUSYWAIT follow their combinational equations, so any pending request reads as stalled.
- Reset mid-access: memory controls drop immediately (asynchronous). The in-flight access is abandoned and no response is given.
- Latency with a zero-wait memory (M_BUSYWAIT low in the ACC cycle):
  - Edge 0: grant.
  - Edge 1: capture, moving to RESP.
  - Busywait is low for the RESP cycle; the requester advances at edge 2.
  - Each access occupies 3 cycles. Each memory wait cycle adds 1.
- M_READ and M_WRITE are asserted for exactly the ACC cycles and are never both nonzero.
- Back-to-back: after RESP the arbiter spends one IDLE cycle before the next grant.
- Simultaneous fetch and data at IDLE: data wins unless starve == STARVE_LIMIT.

## Test plan
- Reset: RST = 0 with I_REQ = 1 and D_READ = 4'b1010. Required response: M_READ = 0, M_WRITE = 0, I_BUSYWAIT = 1, D_BUSYWAIT = 1, no grant. Release reset, then a grant occurs at the next edge.
- Fetch: I_ADDR = 0x10, memory waits 2 cycles, M_READDATA = 0x00500093. Required response: M_READ = 1010 and M_ADDR = 0x10 for 3 cycles. I_DATA = 0x00500093 with I_BUSYWAIT low for exactly one cycle.
- Conflict: I_REQ and D_READ = 4'b1100 (LBU) at 0x40, asserted in the same cycle. Required response: M_ADDR = 0x40 with M_READ = 1100 first, then a fetch after RESP+IDLE. I_BUSYWAIT stays high throughout the data access.
- Starvation: STARVE_LIMIT = 4, D continuously requesting, I_REQ held high. Required response: exactly 4 data grants, then a fetch grant, then the count cleared.
- Store: D_WRITE = 3'b110, D_ADDR = 0x20, D_WRITEDATA = 0xDEADBEEF, with D_READ = 4'b1010 also set. Required response: M_WRITE = 110, M_READ = 0, M_WRITEDATA = 0xDEADBEEF held until M_BUSYWAIT low. D_READDATA is unchanged.
- Reset mid-access: RST asserted while in ACC. Required response: M_READ and M_WRITE drop without waiting for a CLK edge, state returns to IDLE, and no RESP cycle occurs.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: shares one backing memory between the fetch (I) and data (D)
// ports of the core, one access at a time, with a starvation guard for fetch.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        I_REQ,
    input  logic [31:0] I_ADDR,
    output logic [31:0] I_DATA,
    output logic        I_BUSYWAIT,
    input  logic [3:0]  D_READ,
    input  logic [2:0]  D_WRITE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WRITEDATA,
    output logic [31:0] D_READDATA,
    output logic        D_BUSYWAIT,
    output logic [3:0]  M_READ,
    output logic [2:0]  M_WRITE,
    output logic [31:0] M_ADDR,
    output logic [31:0] M_WRITEDATA,
    input  logic [31:0] M_READDATA,
    input  logic        M_BUSYWAIT
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          owner_i_q, owner_i_d;
    logic [CW-1:0] starve_q, starve_d;
    logic [3:0]    m_read_q, m_read_d;
    logic [2:0]    m_write_q, m_write_d;
    logic [31:0]   m_addr_q, m_addr_d;
    logic [31:0]   m_wdata_q, m_wdata_d;
    logic [31:0]   i_data_q, i_data_d;
    logic [31:0]   d_rdata_q, d_rdata_d;

    logic dreq;
    logic grant_i;
    logic grant_d;

    // A write takes precedence when both read and write enables are set.
    assign dreq    = D_READ[3] | D_WRITE[2];
    assign grant_i = I_REQ & (~dreq | (starve_q == STARVE_MAX));
    assign grant_d = ~grant_i & dreq;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            owner_i_q <= 1'b0;
            starve_q  <= '0;
            m_read_q  <= '0;
            m_write_q <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_data_q  <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_i_q <= owner_i_d;
            starve_q  <= starve_d;
            m_read_q  <= m_read_d;
            m_write_q <= m_write_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_data_q  <= i_data_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (grant_i | grant_d) state_d = S_ACC;
            S_ACC:   if (!M_BUSYWAIT) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        owner_i_d = owner_i_q;
        starve_d  = starve_q;
        m_read_d  = m_read_q;
        m_write_d = m_write_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_data_d  = i_data_q;
        d_rdata_d = d_rdata_q;

        if (state_q == S_IDLE) begin
            if (grant_i) begin
                owner_i_d = 1'b1;
                starve_d  = '0;
                m_read_d  = 4'b1010;
                m_write_d = '0;
                m_addr_d  = I_ADDR;
            end else if (grant_d) begin
                owner_i_d = 1'b0;
                // Only data grants that bypass a waiting fetch count towards starvation.
                if (!I_REQ)
                    starve_d = '0;
                else if (starve_q != STARVE_MAX)
                    starve_d = starve_q + CW'(1);
                m_addr_d  = D_ADDR;
                m_wdata_d = D_WRITEDATA;
                if (D_WRITE[2]) begin
                    m_write_d = D_WRITE;
                    m_read_d  = '0;
                end else begin
                    m_read_d  = D_READ;
                    m_write_d = '0;
                end
            end
        end else if (state_q == S_ACC && !M_BUSYWAIT) begin
            if (owner_i_q)
                i_data_d = M_READDATA;
            else if (m_read_q[3])
                d_rdata_d = M_READDATA;
            m_read_d  = '0;
            m_write_d = '0;
        end
    end

    always_comb begin
        I_BUSYWAIT  = I_REQ & ~((state_q == S_RESP) & owner_i_q);
        D_BUSYWAIT  = dreq & ~((state_q == S_RESP) & ~owner_i_q);
        M_READ      = m_read_q;
        M_WRITE     = m_write_q;
        M_ADDR      = m_addr_q;
        M_WRITEDATA = m_wdata_q;
        I_DATA      = i_data_q;
        D_READDATA  = d_rdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model checked every cycle,
// plus hand-computed expectations for reset, fetch, conflict, starvation, store and mid-access reset.
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        I_REQ;
    logic [31:0] I_ADDR;
    logic [31:0] I_DATA;
    logic        I_BUSYWAIT;
    logic [3:0]  D_READ;
    logic [2:0]  D_WRITE;
    logic [31:0] D_ADDR;
    logic [31:0] D_WRITEDATA;
    logic [31:0] D_READDATA;
    logic        D_BUSYWAIT;
    logic [3:0]  M_READ;
    logic [2:0]  M_WRITE;
    logic [31:0] M_ADDR;
    logic [31:0] M_WRITEDATA;
    logic [31:0] M_READDATA;
    logic        M_BUSYWAIT = 1'b0;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_DATA(I_DATA), .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDR(D_ADDR), .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .M_READ(M_READ), .M_WRITE(M_WRITE), .M_ADDR(M_ADDR), .M_WRITEDATA(M_WRITEDATA),
        .M_READDATA(M_READDATA), .M_BUSYWAIT(M_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding access record plus a pending-response flag.
    bit          acc_on, acc_fetch, resp_on, resp_fetch;
    logic [3:0]  acc_rd;
    logic [2:0]  acc_wr;
    logic [31:0] exp_maddr, exp_mwdata, exp_idata, exp_drdata;
    int          starve;
    bit          mdreq;

    task automatic model_clear();
        acc_on = 0; acc_fetch = 0; resp_on = 0; resp_fetch = 0;
        acc_rd = '0; acc_wr = '0;
        exp_maddr = '0; exp_mwdata = '0; exp_idata = '0; exp_drdata = '0;
        starve = 0;
    endtask

    initial model_clear();
    always @(negedge RST) model_clear();

    always @(posedge CLK) begin
        if (!RST) begin
            model_clear();
        end else if (resp_on) begin
            resp_on = 0;
        end else if (acc_on) begin
            if (!M_BUSYWAIT) begin
                if (acc_fetch) exp_idata = M_READDATA;
                else if (acc_wr == 3'b000) exp_drdata = M_READDATA;
                acc_on = 0;
                resp_on = 1;
                resp_fetch = acc_fetch;
            end
        end else begin
            mdreq = D_READ[3] || D_WRITE[2];
            if (I_REQ && (!mdreq || starve == LIMIT)) begin
                acc_on = 1; acc_fetch = 1; acc_rd = 4'b1010; acc_wr = '0;
                exp_maddr = I_ADDR; starve = 0;
            end else if (mdreq) begin
                acc_on = 1; acc_fetch = 0;
                exp_maddr = D_ADDR; exp_mwdata = D_WRITEDATA;
                if (D_WRITE[2]) begin acc_wr = D_WRITE; acc_rd = '0; end
                else begin acc_rd = D_READ; acc_wr = '0; end
                starve = I_REQ ? ((starve + 1 > LIMIT) ? LIMIT : starve + 1) : 0;
            end
        end
    end

    always @(negedge CLK) begin
        chk("m_read", 32'(M_READ), acc_on ? 32'(acc_rd) : 32'd0);
        chk("m_write", 32'(M_WRITE), acc_on ? 32'(acc_wr) : 32'd0);
        if (acc_on) chk("m_addr", M_ADDR, exp_maddr);
        if (acc_on && acc_wr != 3'b000) chk("m_writedata", M_WRITEDATA, exp_mwdata);
        chk("i_data", I_DATA, exp_idata);
        chk("d_readdata", D_READDATA, exp_drdata);
        chk("i_busywait", 32'(I_BUSYWAIT), 32'(I_REQ && !(resp_on && resp_fetch)));
        chk("d_busywait", 32'(D_BUSYWAIT), 32'((D_READ[3] || D_WRITE[2]) && !(resp_on && !resp_fetch)));
    end

    // Memory responder: holds M_BUSYWAIT high for wait_n ACC cycles of each access.
    int wait_n = 0;
    int wcnt = 0;
    always @(negedge CLK) begin
        #2;
        if (M_READ[3] || M_WRITE[2]) begin
            if (wcnt < wait_n) begin M_BUSYWAIT = 1'b1; wcnt++; end
            else M_BUSYWAIT = 1'b0;
        end else begin
            wcnt = 0;
            M_BUSYWAIT = 1'b0;
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    logic [31:0] glog_addr [0:15];
    logic [3:0]  glog_rd   [0:15];
    int          glog_cyc  [0:15];
    int          ng, acc_cnt, resp_cnt, wcyc;
    bit          prev_act, act, d_done, found, got;

    task automatic log_grant(input int cyc);
        act = (M_READ != 4'b0000) || (M_WRITE != 3'b000);
        if (act && !prev_act && ng < 16) begin
            glog_addr[ng] = M_ADDR;
            glog_rd[ng]   = M_READ;
            glog_cyc[ng]  = cyc;
            $display("grant %0d addr=%h m_read=%b m_write=%b", ng, M_ADDR, M_READ, M_WRITE);
            ng++;
        end
        prev_act = act;
    endtask

    initial begin
        RST = 1'b0; I_REQ = 1'b1; I_ADDR = 32'h10;
        D_READ = 4'b1010; D_WRITE = 3'b000; D_ADDR = 32'h100; D_WRITEDATA = '0;
        M_READDATA = 32'h11111111; wait_n = 0;

        // Reset with both requests pending
        step(); step();
        chk("rst_m_read", 32'(M_READ), 32'd0);
        chk("rst_m_write", 32'(M_WRITE), 32'd0);
        chk("rst_i_busy", 32'(I_BUSYWAIT), 32'd1);
        chk("rst_d_busy", 32'(D_BUSYWAIT), 32'd1);
        chk("rst_i_data", I_DATA, 32'd0);
        RST = 1'b1;
        step();
        chk("first_grant_m_read", 32'(M_READ), 32'h0000000A);
        chk("first_grant_addr", M_ADDR, 32'h100);
        step();
        chk("first_resp_d_busy", 32'(D_BUSYWAIT), 32'd0);
        chk("first_resp_i_busy", 32'(I_BUSYWAIT), 32'd1);
        chk("first_resp_rdata", D_READDATA, 32'h11111111);
        D_READ = 4'b0000;
        M_READDATA = 32'h00500093;
        wait_n = 2;

        // Fetch with a 2-cycle memory wait
        acc_cnt = 0; resp_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (M_READ == 4'b1010 && M_ADDR == 32'h10) acc_cnt++;
            if (I_REQ && !I_BUSYWAIT) begin
                resp_cnt++;
                chk("fetch_resp_i_data", I_DATA, 32'h00500093);
                I_REQ = 1'b0;
            end
        end
        chk("fetch_acc_cycles", 32'(acc_cnt), 32'd3);
        chk("fetch_resp_count", 32'(resp_cnt), 32'd1);

        // Simultaneous fetch and LBU: data first, fetch after RESP+IDLE
        I_REQ = 1'b1; I_ADDR = 32'h14;
        D_READ = 4'b1100; D_ADDR = 32'h40;
        wait_n = 1; M_READDATA = 32'hA5A5A5A5;
        ng = 0; prev_act = 0; d_done = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            log_grant(c);
            if (!d_done) chk("conflict_i_stall", 32'(I_BUSYWAIT), 32'd1);
            if (!d_done && !D_BUSYWAIT) begin
                d_done = 1;
                chk("conflict_d_rdata", D_READDATA, 32'hA5A5A5A5);
                D_READ = 4'b0000;
            end
            if (I_REQ && !I_BUSYWAIT) I_REQ = 1'b0;
        end
        chk("conflict_grants", 32'(ng), 32'd2);
        chk("conflict_first_addr", glog_addr[0], 32'h40);
        chk("conflict_first_rd", 32'(glog_rd[0]), 32'h0000000C);
        chk("conflict_second_addr", glog_addr[1], 32'h14);
        chk("conflict_gap", 32'(glog_cyc[1] - glog_cyc[0]), 32'd4);

        // Starvation: data never lets go, fetch held high
        I_REQ = 1'b1; I_ADDR = 32'h80;
        D_READ = 4'b1010; D_ADDR = 32'h200;
        wait_n = 0; M_READDATA = 32'h0BADF00D;
        ng = 0; prev_act = 0;
        for (int c = 0; c < 60 && ng < 10; c++) begin
            step();
            log_grant(c);
        end
        chk("starve_grants", 32'(ng), 32'd10);
        for (int g = 0; g < 10; g++)
            chk($sformatf("starve_grant%0d_addr", g), glog_addr[g],
                (g == 4 || g == 9) ? 32'h80 : 32'h200);
        I_REQ = 1'b0; D_READ = 4'b0000;
        for (int c = 0; c < 6; c++) step();

        // Store with read enable also set: write wins, D_READDATA untouched
        chk("store_pre_rdata", D_READDATA, 32'h0BADF00D);
        D_WRITE = 3'b110; D_READ = 4'b1010; D_ADDR = 32'h20; D_WRITEDATA = 32'hDEADBEEF;
        wait_n = 3; M_READDATA = 32'h12345678;
        wcyc = 0; got = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (M_WRITE != 3'b000) begin
                wcyc++;
                chk("store_m_write", 32'(M_WRITE), 32'h6);
                chk("store_m_read", 32'(M_READ), 32'd0);
                chk("store_m_wdata", M_WRITEDATA, 32'hDEADBEEF);
                chk("store_m_addr", M_ADDR, 32'h20);
            end
            if (D_WRITE[2] && !D_BUSYWAIT) begin
                got = 1;
                D_WRITE = 3'b000; D_READ = 4'b0000;
            end
        end
        chk("store_write_cycles", 32'(wcyc), 32'd4);
        chk("store_resp", 32'(got), 32'd1);
        chk("store_rdata_unchanged", D_READDATA, 32'h0BADF00D);

        // Reset in the middle of a long fetch
        I_REQ = 1'b1; I_ADDR = 32'h30; wait_n = 10; found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            step();
            if (M_READ != 4'b0000) found = 1;
        end
        chk("mid_grant_seen", 32'(found), 32'd1);
        step();
        #2;
        RST = 1'b0;
        #1;
        chk("mid_rst_m_read", 32'(M_READ), 32'd0);
        chk("mid_rst_m_write", 32'(M_WRITE), 32'd0);
        chk("mid_rst_i_data", I_DATA, 32'd0);
        chk("mid_rst_i_busy", 32'(I_BUSYWAIT), 32'd1);
        step();
        RST = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("mid_no_resp", 32'(I_BUSYWAIT), 32'd1);
        end
        chk("mid_regrant_m_read", 32'(M_READ), 32'h0000000A);
        I_REQ = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
